// File: rtl/truth_table_capture.sv
// truth_table_capture: exhaustive sweep of a 4-input function under test.
// Builds the minterm vector and compares it against a latched golden mask.
module truth_table_capture #(
  parameter int N_VARS        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_VARS)-1:0] expected,
  input  logic                   f_in,
  output logic [N_VARS-1:0]      var_bus,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_VARS)-1:0] minterms,
  output logic                   match
);

  localparam int W  = 1 << N_VARS;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [N_VARS-1:0] LAST_PAT = '1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              r_state;
  logic [N_VARS-1:0]   r_var_bus;
  logic [CW-1:0]       r_cnt;
  logic [W-1:0]        r_minterms;
  logic [W-1:0]        r_expected;
  logic                r_busy;
  logic                r_done;
  logic                r_match;

  logic [W-1:0]        w_next_min;
  logic                w_capture;
  logic                w_last;

  // Vector as it will look once the current pattern's F is folded in.
  always_comb begin
    w_next_min            = r_minterms;
    w_next_min[r_var_bus] = f_in;
  end

  assign w_capture = (r_cnt == CNT_LAST);
  assign w_last    = (r_var_bus == LAST_PAT);

  // Sweep sequencer; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_var_bus  <= '0;
      r_cnt      <= '0;
      r_minterms <= '0;
      r_expected <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_match    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= SETTLE;
            r_var_bus  <= '0;
            r_cnt      <= '0;
            r_minterms <= '0;
            r_match    <= 1'b0;
            r_expected <= expected;
            r_busy     <= 1'b1;
          end
        end
        SETTLE: begin
          if (w_capture) begin
            r_minterms <= w_next_min;
            r_cnt      <= '0;
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_match <= (w_next_min == r_expected);
            end else begin
              r_var_bus <= r_var_bus + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_done    <= 1'b0;
          r_var_bus <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign var_bus  = r_var_bus;
  assign busy     = r_busy;
  assign done     = r_done;
  assign minterms = r_minterms;
  assign match    = r_match;

endmodule

// File: tb/tb_truth_table_capture.sv
// tb_truth_table_capture: directed sweeps against bench models of Q46A/Q46B.
// Checks pattern timing, capture, match, start filtering, reset abort.
module tb_truth_table_capture;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] expected;
  logic        f_in;
  logic [3:0]  var_bus;
  logic        busy;
  logic        done;
  logic [15:0] minterms;
  logic        match;

  int n_total = 0;
  int n_bad   = 0;

  logic [1:0] mode;
  logic       glitch_val;

  truth_table_capture dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .expected (expected),
    .f_in     (f_in),
    .var_bus  (var_bus),
    .busy     (busy),
    .done     (done),
    .minterms (minterms),
    .match    (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: F=1, 1: Q46A, 2: Q46B, 3: bench-driven glitch pattern
  function automatic logic f_model(input logic [1:0] m,
                                   input logic [3:0] v);
    logic a, b, c, d;
    logic [15:0] q46b;
    {a, b, c, d} = v;
    q46b = 16'hF7BB;
    case (m)
      2'd0: f_model = 1'b1;
      2'd1: f_model = (~b & ~d) | (~a & b & ~c & d) | (a & b & c & ~d);
      2'd2: f_model = q46b[v];
      default: f_model = 1'b0;
    endcase
  endfunction

  assign f_in = (mode == 2'd3) ? glitch_val : f_model(mode, var_bus);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Full sweep; optional stray start pulse in cycle repulse_at.
  task automatic sweep(input string tag, input logic [1:0] m,
                       input logic [15:0] exp_mask,
                       input logic [15:0] want_min,
                       input logic want_match, input int repulse_at);
    logic seq_ok;
    mode       = m;
    glitch_val = 1'b0;
    expected   = exp_mask;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    expected = ~exp_mask;
    seq_ok   = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      glitch_val = (k % 2 == 0);
      start      = (k == repulse_at);
      if (var_bus !== 4'((k - 1) / 2) || busy !== 1'b1 || done !== 1'b0)
        seq_ok = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_seq"}, 32'(seq_ok), 32'd1);
    @(negedge clk);
    chk({tag, "_done"}, 32'({done, busy}), 32'b10);
    chk({tag, "_min"}, 32'(minterms), 32'(want_min));
    chk({tag, "_match"}, 32'(match), 32'(want_match));
    @(negedge clk);
    chk({tag, "_post"}, 32'({done, busy, var_bus}), 32'd0);
    chk({tag, "_hold"}, 32'({match, minterms}), 32'({want_match, want_min}));
  endtask

  initial begin
    int cyc;
    rst_n      = 1'b0;
    start      = 1'b0;
    expected   = 16'h0;
    mode       = 2'd0;
    glitch_val = 1'b0;
    #1;
    chk("rst_state", 32'({busy, done, match, var_bus, minterms}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_state", 32'({busy, done, match, var_bus}), 32'd0);

    sweep("ones",  2'd0, 16'hFFFF, 16'hFFFF, 1'b1, 0);
    sweep("q46a",  2'd1, 16'h4525, 16'h4525, 1'b1, 0);
    sweep("q46b",  2'd2, 16'hF7BA, 16'hF7BB, 1'b0, 0);
    sweep("glitch", 2'd3, 16'hFFFF, 16'hFFFF, 1'b1, 0);
    sweep("restart", 2'd1, 16'h4525, 16'h4525, 1'b1, 10);

    mode     = 2'd0;
    expected = 16'hFFFF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", 32'({busy, var_bus}), 32'h19);
    rst_n = 1'b0;
    #1;
    chk("rst_abort",
        32'({busy, done, var_bus, minterms}), 32'd0);
    @(negedge clk);
    chk("rst_nodone", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    sweep("after_rst", 2'd1, 16'h4525, 16'h4525, 1'b1, 0);

    mode     = 2'd0;
    expected = 16'hFFFF;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < 40);
    chk("b2b_done_lat", 32'(cyc), 32'd33);
    @(negedge clk);
    chk("b2b_idle", 32'({busy, done, minterms}), 32'h0FFFF);
    @(negedge clk);
    chk("b2b_accept", 32'({busy, var_bus, minterms}), 32'h100000);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_done2", 32'(cyc), 32'd33);
    chk("b2b_min2", 32'({match, minterms}), 32'h1FFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
